// File: rtl/bsg_gateway_power_seq_pkg.sv
// Shared types and widths for the gateway ASIC power sequencer.
package bsg_gateway_power_seq_pkg;

  localparam int state_width_lp = 4;
  localparam int dwell_width_lp = 16;

  typedef enum logic [state_width_lp-1:0] {
    IDLE     = 4'd0,
    IO_UP    = 4'd1,
    CORE_UP  = 4'd2,
    PLL_UP   = 4'd3,
    LDO_UP   = 4'd4,
    PLL_CFG  = 4'd5,
    LINK_RST = 4'd6,
    CALIB    = 4'd7,
    RUN      = 4'd8,
    DOWN     = 4'd9,
    FAULT    = 4'd10
  } state_e;

endpackage

// File: rtl/bsg_gateway_power_seq_timer.sv
// Saturating down-counter; expire_o is high value_i+1 cycles after a load.
module bsg_gateway_power_seq_timer
  import bsg_gateway_power_seq_pkg::*;
#(
  parameter int width_p = dwell_width_lp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] value_i,
  output logic               expire_o
);

  logic [width_p-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/bsg_gateway_power_seq.sv
// Gateway ASIC power-up / power-down sequencer with comm-link bring-up.
// Define BSG_GATEWAY_POWER_SEQ_TIMEOUT_EN to add calibration timeout, retry and FAULT.
module bsg_gateway_power_seq
  import bsg_gateway_power_seq_pkg::*;
#(
  parameter int rail_delay_p    = 1024,
  parameter int calib_timeout_p = 1 << 20,
  parameter int max_retries_p   = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      shutdown_i,
  input  logic                      pll_done_i,
  input  logic                      calib_done_i,
  output logic                      io_en_o,
  output logic                      core_en_o,
  output logic                      pll_en_o,
  output logic                      ldo_en_o,
  output logic                      pll_cfg_start_o,
  output logic                      link_reset_o,
  output logic                      fault_o,
  output logic [state_width_lp-1:0] state_o
);

  localparam logic [dwell_width_lp-1:0] dwell_load_lp = dwell_width_lp'(rail_delay_p - 1);

  state_e     state_q, state_d;
  logic [1:0] step_q, step_d;
  logic [3:0] rail_q, rail_d;  // {ldo, pll, core, io}
  logic       cfg_q, lrst_q;
  logic       dwell_load, dwell_expire;
  logic       calib_expire, retry_exhausted;

  bsg_gateway_power_seq_timer #(.width_p(dwell_width_lp)) dwell_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (dwell_load),
    .value_i (dwell_load_lp),
    .expire_o(dwell_expire)
  );

`ifdef BSG_GATEWAY_POWER_SEQ_TIMEOUT_EN
  localparam int tmo_width_lp   = $clog2(calib_timeout_p + 1);
  localparam int retry_width_lp = (max_retries_p < 1) ? 1 : $clog2(max_retries_p + 1);

  logic [retry_width_lp-1:0] retry_q, retry_d;
  logic                      tmo_load, fault_q;

  assign tmo_load = (state_d == CALIB) && (state_q != CALIB);

  bsg_gateway_power_seq_timer #(.width_p(tmo_width_lp)) calib_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (tmo_load),
    .value_i (tmo_width_lp'(calib_timeout_p - 1)),
    .expire_o(calib_expire)
  );

  assign retry_exhausted = (retry_q == retry_width_lp'(max_retries_p));

  always_comb begin
    retry_d = retry_q;
    if ((state_q == IDLE) || ((state_d == RUN) && (state_q != RUN))) begin
      retry_d = '0;
    end else if ((state_q == CALIB) && (state_d == LINK_RST)) begin
      retry_d = retry_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      retry_q <= '0;
      fault_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
      if (state_d == FAULT) begin
        fault_q <= 1'b1;
      end else if (state_d == IDLE) begin
        fault_q <= 1'b0;
      end
    end
  end

  assign fault_o = fault_q;
`else
  // Timeout parameters only matter when the timeout feature is built in.
  logic unused_cfg;
  assign unused_cfg      = ^{32'(calib_timeout_p), 32'(max_retries_p)};
  assign calib_expire    = 1'b0;
  assign retry_exhausted = 1'b0;
  assign fault_o         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    rail_d     = rail_q;
    dwell_load = 1'b0;
    if (shutdown_i && (state_q != IDLE) && (state_q != DOWN)) begin
      state_d = DOWN;
    end else begin
      unique case (state_q)
        IDLE:     if (start_i && !shutdown_i) state_d = IO_UP;
        IO_UP:    if (dwell_expire) state_d = CORE_UP;
        CORE_UP:  if (dwell_expire) state_d = PLL_UP;
        PLL_UP:   if (dwell_expire) state_d = LDO_UP;
        LDO_UP:   if (dwell_expire) state_d = PLL_CFG;
        PLL_CFG:  if (pll_done_i) state_d = LINK_RST;
        LINK_RST: if (dwell_expire) state_d = CALIB;
        CALIB: begin
          if (calib_done_i) begin
            state_d = RUN;
          end else if (calib_expire) begin
            state_d = retry_exhausted ? FAULT : LINK_RST;
          end
        end
        RUN:      if (!calib_done_i) state_d = LINK_RST;
        DOWN: begin
          // One rail per dwell period; the final dwell returns to IDLE.
          if (dwell_expire) begin
            if (step_q == 2'd3) begin
              state_d = IDLE;
            end else begin
              step_d     = step_q + 2'd1;
              dwell_load = 1'b1;
            end
          end
        end
        FAULT:    state_d = FAULT;
        default:  state_d = IDLE;
      endcase
    end

    if (state_d != state_q) begin
      dwell_load = 1'b1;
      step_d     = 2'd0;
      case (state_d)
        IO_UP:   rail_d[0] = 1'b1;
        CORE_UP: rail_d[1] = 1'b1;
        PLL_UP:  rail_d[2] = 1'b1;
        LDO_UP:  rail_d[3] = 1'b1;
        default: ;
      endcase
    end

    if ((state_d == DOWN) && dwell_load) begin
      rail_d[2'd3 - step_d] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      rail_q  <= 4'd0;
      cfg_q   <= 1'b0;
      lrst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rail_q  <= rail_d;
      cfg_q   <= (state_d == PLL_CFG) && (state_q != PLL_CFG);
      lrst_q  <= !((state_d == CALIB) || (state_d == RUN));
    end
  end

  assign io_en_o         = rail_q[0];
  assign core_en_o       = rail_q[1];
  assign pll_en_o        = rail_q[2];
  assign ldo_en_o        = rail_q[3];
  assign pll_cfg_start_o = cfg_q;
  assign link_reset_o    = lrst_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_bsg_gateway_power_seq.sv
// Self-checking bench for bsg_gateway_power_seq (rail 4, timeout 16, retries 2).
module tb_bsg_gateway_power_seq;

  localparam int RD = 4;
  localparam int TO = 16;
  localparam int MR = 2;

  localparam logic [3:0] S_IDLE = 4'd0, S_IO_UP = 4'd1, S_CORE_UP = 4'd2, S_PLL_UP = 4'd3,
                         S_LDO_UP = 4'd4, S_PLL_CFG = 4'd5, S_LINK_RST = 4'd6, S_CALIB = 4'd7,
                         S_RUN = 4'd8, S_DOWN = 4'd9, S_FAULT = 4'd10;

  logic clk_i = 1'b0;
  logic reset_i, start_i, shutdown_i, pll_done_i, calib_done_i;
  logic io_en_o, core_en_o, pll_en_o, ldo_en_o, pll_cfg_start_o, link_reset_o, fault_o;
  logic [3:0] state_o;
  logic [10:0] obs;

  int total = 0;
  int bad   = 0;

  // expected output vectors and per-sample input drive {shutdown, calib_done, pll_done}
  logic [10:0] exp_q[$];
  logic [2:0]  drv_q[$];

  always #5 clk_i = ~clk_i;

  bsg_gateway_power_seq #(.rail_delay_p(RD), .calib_timeout_p(TO), .max_retries_p(MR)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .shutdown_i(shutdown_i),
    .pll_done_i(pll_done_i), .calib_done_i(calib_done_i),
    .io_en_o(io_en_o), .core_en_o(core_en_o), .pll_en_o(pll_en_o), .ldo_en_o(ldo_en_o),
    .pll_cfg_start_o(pll_cfg_start_o), .link_reset_o(link_reset_o), .fault_o(fault_o),
    .state_o(state_o)
  );

  assign obs = {state_o, io_en_o, core_en_o, pll_en_o, ldo_en_o, pll_cfg_start_o, link_reset_o, fault_o};

  // rails = {io, core, pll, ldo}; link reset is low only in CALIB and RUN
  function automatic logic [10:0] ev(logic [3:0] st, logic [3:0] rails, logic cfg, logic flt);
    return {st, rails, cfg, !((st == S_CALIB) || (st == S_RUN)), flt};
  endfunction

  // rails switch on cumulatively as the up-sequence advances
  function automatic logic [3:0] rails_up(logic [3:0] st);
    return {st >= 4'd1, st >= 4'd2, st >= 4'd3, st >= 4'd4};
  endfunction

  function automatic void push(logic [10:0] v, int n, logic [2:0] d);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(v);
      drv_q.push_back(d);
    end
  endfunction

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_i = 1'b1; start_i = 1'b0; shutdown_i = 1'b0; pll_done_i = 1'b0; calib_done_i = 1'b0;
    tick(); tick();
    reset_i = 1'b0;
    tick();
  endtask

  // Drive from IDLE up to CALIB (c=0: stop at first CALIB sample) or RUN (c>=1).
  task automatic bring_up(input int j, input int c);
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (16 + j) tick();
    pll_done_i = 1'b1; tick(); pll_done_i = 1'b0;
    repeat (RD) tick();
    if (c > 0) begin
      repeat (c - 1) tick();
      calib_done_i = 1'b1; tick();
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b0; shutdown_i = 1'b0; pll_done_i = 1'b0; calib_done_i = 1'b0;
    tick();
    total++;
    if (obs !== ev(S_IDLE, 4'h0, 1'b0, 1'b0)) begin
      bad++; $display("FAIL reset_held got=%b want=%b", obs, ev(S_IDLE, 4'h0, 1'b0, 1'b0));
    end
    reset_i = 1'b0;
    repeat (3) tick();
    total++;
    if (obs !== ev(S_IDLE, 4'h0, 1'b0, 1'b0)) begin
      bad++; $display("FAIL reset_released got=%b want=%b", obs, ev(S_IDLE, 4'h0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_power_up(input int j, input int c);
    exp_q.delete(); drv_q.delete();
    push(ev(S_IO_UP, rails_up(S_IO_UP), 1'b0, 1'b0), 2, 3'b000);
    push(ev(S_IO_UP, rails_up(S_IO_UP), 1'b0, 1'b0), 1, 3'b001);  // early pll_done ignored
    push(ev(S_IO_UP, rails_up(S_IO_UP), 1'b0, 1'b0), RD - 3, 3'b000);
    push(ev(S_CORE_UP, rails_up(S_CORE_UP), 1'b0, 1'b0), RD, 3'b000);
    push(ev(S_PLL_UP, rails_up(S_PLL_UP), 1'b0, 1'b0), RD, 3'b000);
    push(ev(S_LDO_UP, rails_up(S_LDO_UP), 1'b0, 1'b0), RD, 3'b000);
    if (j == 0) begin
      push(ev(S_PLL_CFG, 4'hF, 1'b1, 1'b0), 1, 3'b001);
    end else begin
      push(ev(S_PLL_CFG, 4'hF, 1'b1, 1'b0), 1, 3'b000);
      push(ev(S_PLL_CFG, 4'hF, 1'b0, 1'b0), j - 1, 3'b000);
      push(ev(S_PLL_CFG, 4'hF, 1'b0, 1'b0), 1, 3'b001);
    end
    push(ev(S_LINK_RST, 4'hF, 1'b0, 1'b0), RD, 3'b000);
    push(ev(S_CALIB, 4'hF, 1'b0, 1'b0), c - 1, 3'b000);
    push(ev(S_CALIB, 4'hF, 1'b0, 1'b0), 1, 3'b010);
    push(ev(S_RUN, 4'hF, 1'b0, 1'b0), 3, 3'b010);
    start_i = 1'b1; tick(); start_i = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs !== exp_q[i]) begin
        bad++; $display("FAIL power_up j=%0d c=%0d idx=%0d got=%b want=%b", j, c, i, obs, exp_q[i]);
      end
      {shutdown_i, calib_done_i, pll_done_i} = drv_q[i];
      tick();
    end
  endtask

  task automatic test_shutdown(input int k0);
    logic [3:0] s0, st, rails;
    logic cfg;
    int m;
    s0 = (k0 < 16) ? 4'(1 + k0 / 4) : S_PLL_CFG;
    start_i = 1'b1; tick(); start_i = 1'b0;
    for (int i = 0; i < k0 + 19; i++) begin
      if (i <= k0) begin
        st = (i < 16) ? 4'(1 + i / 4) : S_PLL_CFG;
        rails = rails_up(st); cfg = (i == 16);
      end else if (i <= k0 + 16) begin
        m = i - k0 - 1;
        st = S_DOWN; cfg = 1'b0;
        rails = rails_up(s0) & {m < 12, m < 8, m < 4, 1'b0};
      end else begin
        st = S_IDLE; rails = 4'h0; cfg = 1'b0;
      end
      total++;
      if (obs !== ev(st, rails, cfg, 1'b0)) begin
        bad++; $display("FAIL shutdown k0=%0d idx=%0d got=%b want=%b", k0, i, obs, ev(st, rails, cfg, 1'b0));
      end
      shutdown_i = (i == k0);
      start_i    = (i == k0 + 6);  // start during DOWN is ignored
      tick();
    end
    start_i = 1'b0;
  endtask

  task automatic test_run_drop(input int j, input int c, input int d);
    bring_up(j, c);
    exp_q.delete(); drv_q.delete();
    push(ev(S_RUN, 4'hF, 1'b0, 1'b0), 1, 3'b000);
    push(ev(S_LINK_RST, 4'hF, 1'b0, 1'b0), RD, 3'b000);
    push(ev(S_CALIB, 4'hF, 1'b0, 1'b0), d - 1, 3'b000);
    push(ev(S_CALIB, 4'hF, 1'b0, 1'b0), 1, 3'b010);
    push(ev(S_RUN, 4'hF, 1'b0, 1'b0), 2, 3'b010);
    push(ev(S_RUN, 4'hF, 1'b0, 1'b0), 1, 3'b110);
    for (int m = 0; m < 4 * RD; m++)
      push(ev(S_DOWN, {m < 3 * RD, m < 2 * RD, m < RD, 1'b0}, 1'b0, 1'b0), 1, 3'b010);
    push(ev(S_IDLE, 4'h0, 1'b0, 1'b0), 2, 3'b000);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs !== exp_q[i]) begin
        bad++; $display("FAIL run_drop d=%0d idx=%0d got=%b want=%b", d, i, obs, exp_q[i]);
      end
      {shutdown_i, calib_done_i, pll_done_i} = drv_q[i];
      tick();
    end
  endtask

`ifdef BSG_GATEWAY_POWER_SEQ_TIMEOUT_EN
  task automatic test_timeout(input int j, input bit pre);
    bring_up(j, 0);
    exp_q.delete(); drv_q.delete();
    if (pre) begin
      // one timeout, then a successful calibration must clear the retry count
      push(ev(S_CALIB, 4'hF, 1'b0, 1'b0), TO, 3'b000);
      push(ev(S_LINK_RST, 4'hF, 1'b0, 1'b0), RD, 3'b000);
      push(ev(S_CALIB, 4'hF, 1'b0, 1'b0), 2, 3'b000);
      push(ev(S_CALIB, 4'hF, 1'b0, 1'b0), 1, 3'b010);
      push(ev(S_RUN, 4'hF, 1'b0, 1'b0), 1, 3'b010);
      push(ev(S_RUN, 4'hF, 1'b0, 1'b0), 1, 3'b000);
      push(ev(S_LINK_RST, 4'hF, 1'b0, 1'b0), RD, 3'b000);
    end
    for (int r = 0; r <= MR; r++) begin
      push(ev(S_CALIB, 4'hF, 1'b0, 1'b0), TO, 3'b000);
      if (r < MR) push(ev(S_LINK_RST, 4'hF, 1'b0, 1'b0), RD, 3'b000);
    end
    push(ev(S_FAULT, 4'hF, 1'b0, 1'b1), 3, 3'b000);
    push(ev(S_FAULT, 4'hF, 1'b0, 1'b1), 1, 3'b100);
    for (int m = 0; m < 4 * RD; m++)
      push(ev(S_DOWN, {m < 3 * RD, m < 2 * RD, m < RD, 1'b0}, 1'b0, 1'b1), 1, 3'b000);
    push(ev(S_IDLE, 4'h0, 1'b0, 1'b0), 3, 3'b000);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs !== exp_q[i]) begin
        bad++; $display("FAIL timeout pre=%0d idx=%0d got=%b want=%b", pre, i, obs, exp_q[i]);
      end
      {shutdown_i, calib_done_i, pll_done_i} = drv_q[i];
      tick();
    end
  endtask
`else
  task automatic test_calib_wait(input int j);
    bring_up(j, 0);
    for (int i = 0; i < 3 * TO + 10; i++) begin
      total++;
      if (obs !== ev(S_CALIB, 4'hF, 1'b0, 1'b0)) begin
        bad++; $display("FAIL calib_wait idx=%0d got=%b want=%b", i, obs, ev(S_CALIB, 4'hF, 1'b0, 1'b0));
      end
      calib_done_i = (i == 3 * TO + 9);
      tick();
    end
    total++;
    if (obs !== ev(S_RUN, 4'hF, 1'b0, 1'b0)) begin
      bad++; $display("FAIL calib_wait_run got=%b want=%b", obs, ev(S_RUN, 4'hF, 1'b0, 1'b0));
    end
  endtask
`endif

  task automatic test_async_reset();
    logic [3:0] st;
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (16) tick();
    total++;
    if (obs !== ev(S_PLL_CFG, 4'hF, 1'b1, 1'b0)) begin
      bad++; $display("FAIL pll_cfg_entry got=%b want=%b", obs, ev(S_PLL_CFG, 4'hF, 1'b1, 1'b0));
    end
    #2 reset_i = 1'b1;
    #1;
    total++;
    if (obs !== ev(S_IDLE, 4'h0, 1'b0, 1'b0)) begin
      bad++; $display("FAIL async_reset got=%b want=%b", obs, ev(S_IDLE, 4'h0, 1'b0, 1'b0));
    end
    tick();
    reset_i = 1'b0; start_i = 1'b1; shutdown_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (obs !== ev(S_IDLE, 4'h0, 1'b0, 1'b0)) begin
        bad++; $display("FAIL start_and_shutdown idx=%0d got=%b want=%b", i, obs, ev(S_IDLE, 4'h0, 1'b0, 1'b0));
      end
    end
    shutdown_i = 1'b0;
    tick();
    start_i = 1'b0;
    for (int i = 0; i <= RD; i++) begin
      st = (i < RD) ? S_IO_UP : S_CORE_UP;
      total++;
      if (obs !== ev(st, rails_up(st), 1'b0, 1'b0)) begin
        bad++; $display("FAIL post_reset_dwell idx=%0d got=%b want=%b", i, obs, ev(st, rails_up(st), 1'b0, 1'b0));
      end
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_power_up(0, 2);
    do_reset(); test_shutdown(5);
    do_reset(); test_run_drop(1, 2, 3);
`ifdef BSG_GATEWAY_POWER_SEQ_TIMEOUT_EN
    do_reset(); test_timeout(2, 1'b0);
    do_reset(); test_timeout(int'($urandom_range(0, 3)), 1'b1);
`else
    do_reset(); test_calib_wait(1);
`endif
    do_reset(); test_async_reset();
    for (int n = 0; n < 8; n++) begin
      do_reset();
      case ($urandom_range(0, 2))
        0: test_power_up(int'($urandom_range(0, 4)), int'($urandom_range(1, TO)));
        1: test_shutdown(int'($urandom_range(0, 19)));
        default: test_run_drop(int'($urandom_range(0, 3)), int'($urandom_range(1, TO)),
                               int'($urandom_range(1, TO)));
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_gateway_power_seq.md
BSG_GATEWAY_POWER_SEQ -- requirements
Module: bsg_gateway_power_seq

Interface
REQ-001 SHALL have parameter rail_delay_p, default 1024: dwell cycles per rail step and link-reset hold, legal range 1..2^16-1.
REQ-002 SHALL have parameter calib_timeout_p, default 2^20: cycles allowed in CALIB before a retry (macro builds only).
REQ-003 SHALL have parameter max_retries_p, default 3: number of calibration retries before FAULT (macro builds only).
REQ-004 SHALL have ports:
- clk_i  in  1  sole clock
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  level request to power up
- shutdown_i  in  1  level request to power down
- pll_done_i  in  1  PLL SPI configuration complete
- calib_done_i  in  1  comm-link core calibration done
- io_en_o, core_en_o, pll_en_o, ldo_en_o  out  1 each  ASIC rail enables
- pll_cfg_start_o  out  1  one-cycle pulse starting PLL configuration
- link_reset_o  out  1  comm-link async reset
- fault_o  out  1  calibration retries exhausted
- state_o  out  4  current state encoding

Function
REQ-005 SHALL implement states IDLE=0, IO_UP=1, CORE_UP=2, PLL_UP=3, LDO_UP=4, PLL_CFG=5, LINK_RST=6, CALIB=7, RUN=8, DOWN=9, FAULT=10; state_o SHALL equal the state register.
REQ-006 SHALL register all outputs; outputs change on the clock edge entering a state.
REQ-007 IDLE -> IO_UP when start_i=1 and shutdown_i=0.
REQ-008 IO_UP, CORE_UP, PLL_UP, LDO_UP SHALL each dwell exactly rail_delay_p cycles, asserting io_en_o, core_en_o, pll_en_o, ldo_en_o cumulatively on entry, then advance in that order; LDO_UP -> PLL_CFG.
REQ-009 pll_cfg_start_o SHALL be high exactly the first cycle of PLL_CFG; PLL_CFG -> LINK_RST on pll_done_i=1; pll_done_i in any other state SHALL be ignored.
REQ-010 link_reset_o SHALL be 1 in every state except CALIB and RUN; LINK_RST dwells rail_delay_p cycles then -> CALIB.
REQ-011 CALIB -> RUN on calib_done_i=1; RUN -> LINK_RST when calib_done_i falls to 0.
REQ-012 shutdown_i=1 in any state other than IDLE or DOWN SHALL move to DOWN next cycle, with priority over every other transition that cycle; link_reset_o rises on DOWN entry.
REQ-013 DOWN SHALL clear ldo_en_o, pll_en_o, core_en_o, io_en_o in that order, one per rail_delay_p cycles (first on entry), then -> IDLE after the last step's dwell.
REQ-014 start_i while not in IDLE SHALL be ignored; start_i and shutdown_i both high in IDLE SHALL keep IDLE.
REQ-015 Dwell counter SHALL be 16 bits, reloaded on every state entry, never wrapping.

Reset
REQ-016 reset_i SHALL asynchronously force IDLE, all rail enables 0, pll_cfg_start_o 0, link_reset_o 1, fault_o 0, counters and retry count 0, including mid-sequence.

Configuration
REQ-017 With BSG_GATEWAY_POWER_SEQ_TIMEOUT_EN defined: CALIB running calib_timeout_p cycles without calib_done_i SHALL increment retry count and -> LINK_RST; expiry with retry count = max_retries_p SHALL -> FAULT instead; retry count clears on RUN entry and in IDLE.
REQ-018 FAULT SHALL keep rails on, link_reset_o=1, fault_o=1; exit only via shutdown_i (DOWN); fault_o clears on IDLE entry.
REQ-019 Without the macro: CALIB waits indefinitely, FAULT unreachable, fault_o tied 0, no timeout/retry registers.

Structure
REQ-020 Package bsg_gateway_power_seq_pkg SHALL hold the state enum typedef, state width (4) and dwell counter width (16).
REQ-021 Sub-module bsg_gateway_power_seq_timer (load, value, expire) SHALL implement the dwell/timeout down-counter.

Verification (rail_delay_p=4, calib_timeout_p=16, max_retries_p=2)
REQ-022 start_i pulse, pll_done_i 3 cycles after pulse, calib_done_i 2 cycles into CALIB -> rails rise 4 cycles apart, pll_cfg_start_o single cycle, link_reset_o low entering CALIB, state_o=8.
REQ-023 shutdown_i during CORE_UP cycle 2 -> DOWN next cycle, enables drop ldo/pll/core/io at 4-cycle spacing, state_o=0 after 16 DOWN cycles.
REQ-024 Macro on, calib_done_i never -> two LINK_RST retries 16 CALIB cycles each, then FAULT with fault_o=1; shutdown_i -> IDLE, fault_o=0.
REQ-025 In RUN drop calib_done_i -> LINK_RST, link_reset_o=1 for 4 cycles, re-CALIB.
REQ-026 reset_i asserted mid-PLL_CFG between edges -> outputs at reset values immediately; start_i+shutdown_i together in IDLE -> stays IDLE.
